// File: rtl/alt_vipitc121_mode_update_pkg.sv
// Shared types and constants for the mode-update controller: the FSM state
// encoding, the strobe counter width and the strobe-length legality check.
package alt_vipitc121_mode_update_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOAD    = 2'd2,
        DONE    = 2'd3
    } mode_state_t;

    localparam int LOAD_CNT_W = 4;

    // A load strobe must last between 1 and 16 cycles to fit the 4-bit counter.
    function automatic bit load_cycles_legal(input int cycles);
        return (cycles >= 1) && (cycles <= 16);
    endfunction

endpackage

// File: rtl/alt_vipitc121_mode_update_ctrl_if.sv
// Request/strobe bundle between the sync-domain control logic and the
// mode-update controller. The master side raises requests and watches the
// strobe/ack outputs; the slave side is the controller itself.
interface alt_vipitc121_mode_update_ctrl_if;

    logic enable;
    logic trigger;
    logic frame_boundary;
    logic update_load;
    logic update_busy;
    logic coalesced;
    logic done_toggle;
    logic timeout_flag;

    modport master (
        output enable,
        output trigger,
        output frame_boundary,
        input  update_load,
        input  update_busy,
        input  coalesced,
        input  done_toggle,
        input  timeout_flag
    );

    modport slave (
        input  enable,
        input  trigger,
        input  frame_boundary,
        output update_load,
        output update_busy,
        output coalesced,
        output done_toggle,
        output timeout_flag
    );

endinterface

// File: rtl/alt_vipitc121_mode_update_timer.sv
// Clearable, saturating up-counter. tc is high during a counting cycle whose
// current count equals TERMINAL, so the owner can act on that same cycle.
module alt_vipitc121_mode_update_timer #(
    parameter int CNT_WIDTH = 21,
    parameter int TERMINAL  = (1 << 20) - 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_WIDTH-1:0] TERM_VAL = CNT_WIDTH'(TERMINAL);

    logic [CNT_WIDTH-1:0] count;

    // Clear has priority; counting stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign tc = inc && (count == TERM_VAL);

endmodule

// File: rtl/alt_vipitc121_mode_update_ctrl.sv
// Mode-update controller in the video/sync clock domain. Holds a trigger
// until the next frame boundary, issues a LOAD_CYCLES-wide register-load
// strobe, then flips done_toggle as the acknowledge level. Triggers arriving
// while a request is outstanding are merged and reported on coalesced.
// Optional feature macro: ALT_VIPITC121_UPDATE_TIMEOUT_EN adds a PENDING
// timeout that forces the update after TIMEOUT_CYCLES without a boundary.
module alt_vipitc121_mode_update_ctrl
    import alt_vipitc121_mode_update_pkg::*;
#(
    parameter int LOAD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1 << 20,
    parameter int CNT_WIDTH      = 21
) (
    input logic                             clk,
    input logic                             rst_n,
    alt_vipitc121_mode_update_ctrl_if.slave bus
);

    // An out-of-range strobe length falls back to a single-cycle strobe.
    localparam bit LOAD_OK = load_cycles_legal(LOAD_CYCLES);
    localparam logic [LOAD_CNT_W-1:0] LOAD_LAST =
        LOAD_OK ? LOAD_CNT_W'(LOAD_CYCLES - 1) : '0;

    mode_state_t           state;
    logic [LOAD_CNT_W-1:0] load_cnt;
    logic                  rearm;
    logic                  update_load_q;
    logic                  busy_q;
    logic                  coalesced_q;
    logic                  toggle_q;
    logic                  timeout_q;
    logic                  force_load;

`ifdef ALT_VIPITC121_UPDATE_TIMEOUT_EN
    logic timer_clear;
    logic timer_inc;

    // The timer is held at zero outside PENDING, so it restarts on every entry.
    assign timer_clear = (state != PENDING);
    assign timer_inc   = (state == PENDING);

    alt_vipitc121_mode_update_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .TERMINAL  (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .inc   (timer_inc),
        .tc    (force_load)
    );
`else
    logic unused_cfg;

    assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_WIDTH};
    assign force_load = 1'b0;
`endif

    // Single FSM with registered outputs; every decision shows up next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            load_cnt      <= '0;
            rearm         <= 1'b0;
            update_load_q <= 1'b0;
            busy_q        <= 1'b0;
            coalesced_q   <= 1'b0;
            toggle_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            coalesced_q <= 1'b0;
            timeout_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.trigger && bus.enable) begin
                        state  <= PENDING;
                        busy_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (!bus.enable) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        rearm  <= 1'b0;
                    end else begin
                        coalesced_q <= bus.trigger;
                        if (bus.frame_boundary || force_load) begin
                            state         <= LOAD;
                            load_cnt      <= '0;
                            update_load_q <= 1'b1;
                            timeout_q     <= !bus.frame_boundary;
                        end
                    end
                end
                LOAD: begin
                    if (bus.trigger) begin
                        if (rearm) begin
                            coalesced_q <= 1'b1;
                        end else begin
                            rearm <= 1'b1;
                        end
                    end
                    if (load_cnt == LOAD_LAST) begin
                        state         <= DONE;
                        update_load_q <= 1'b0;
                        toggle_q      <= ~toggle_q;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rearm || bus.trigger) begin
                        state <= PENDING;
                        if (rearm && bus.trigger) begin
                            coalesced_q <= 1'b1;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    rearm <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.update_load  = update_load_q;
    assign bus.update_busy  = busy_q;
    assign bus.coalesced    = coalesced_q;
    assign bus.done_toggle  = toggle_q;
    assign bus.timeout_flag = timeout_q;

endmodule

// File: tb/tb_alt_vipitc121_mode_update_ctrl.sv
// Bench for the mode-update controller: directed scenarios followed by a
// random run, every cycle compared against a behavioural request model.
module tb_alt_vipitc121_mode_update_ctrl;

    localparam int LOAD_CYCLES    = 3;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int CNT_WIDTH      = 4;
`ifdef ALT_VIPITC121_UPDATE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    alt_vipitc121_mode_update_ctrl_if bus ();

    alt_vipitc121_mode_update_ctrl #(
        .LOAD_CYCLES    (LOAD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;

    // Request model: strobe cycles left, waiting for boundary, ack cycle,
    // one queued re-request, number of completed updates, wait age.
    int m_load_left;
    bit m_waiting;
    bit m_done;
    bit m_queued;
    int m_updates;
    int m_age;
    bit m_coal;
    bit m_tflag;

    int  coal_seen;
    int  bursts_seen;
    logic prev_load;

    task automatic modelReset();
        m_load_left = 0;
        m_waiting   = 0;
        m_done      = 0;
        m_queued    = 0;
        m_updates   = 0;
        m_age       = 0;
        m_coal      = 0;
        m_tflag     = 0;
    endtask

    task automatic modelStep(input bit en, input bit trig, input bit fb);
        m_coal  = 0;
        m_tflag = 0;
        if (m_load_left > 0) begin
            if (trig) begin
                if (m_queued) m_coal = 1;
                else m_queued = 1;
            end
            m_load_left--;
            if (m_load_left == 0) begin
                m_done = 1;
                m_updates++;
            end
        end else if (m_done) begin
            if (trig) begin
                if (m_queued) m_coal = 1;
                else m_queued = 1;
            end
            m_done = 0;
            if (m_queued) begin
                m_queued  = 0;
                m_waiting = 1;
                m_age     = 0;
            end
        end else if (m_waiting) begin
            if (!en) begin
                m_waiting = 0;
                m_queued  = 0;
            end else begin
                m_coal = trig;
                if (fb) begin
                    m_waiting   = 0;
                    m_load_left = LOAD_CYCLES;
                end else if (TIMEOUT_EN && m_age == TIMEOUT_CYCLES - 1) begin
                    m_waiting   = 0;
                    m_load_left = LOAD_CYCLES;
                    m_tflag     = 1;
                end else begin
                    m_age++;
                end
            end
        end else if (trig && en) begin
            m_waiting = 1;
            m_age     = 0;
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        check_count++;
        assert (obs === exp) else begin
            error_count++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        check_count++;
        assert (obs == exp) else begin
            error_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkBit({tag, "/update_load"},  bus.update_load,  logic'(m_load_left > 0));
        checkBit({tag, "/update_busy"},  bus.update_busy,
                 logic'(m_waiting || m_load_left > 0 || m_done));
        checkBit({tag, "/coalesced"},    bus.coalesced,    logic'(m_coal));
        checkBit({tag, "/done_toggle"},  bus.done_toggle,  logic'(m_updates % 2));
        checkBit({tag, "/timeout_flag"}, bus.timeout_flag, logic'(m_tflag));
    endtask

    // Drive one cycle of inputs, step the model at the edge, compare after it.
    task automatic applyStimulus(input string tag, input bit en, input bit trig, input bit fb);
        bus.enable         = en;
        bus.trigger        = trig;
        bus.frame_boundary = fb;
        @(posedge clk);
        #1;
        modelStep(en, trig, fb);
        checkOutput(tag);
        if (bus.coalesced === 1'b1) coal_seen++;
        if (bus.update_load === 1'b1 && prev_load !== 1'b1) bursts_seen++;
        prev_load = bus.update_load;
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst_n              = 1'b0;
        bus.enable         = 1'b0;
        bus.trigger        = 1'b0;
        bus.frame_boundary = 1'b0;
        #1;
        modelReset();
        checkOutput("reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold");
        rst_n     = 1'b1;
        prev_load = 1'b0;
    endtask

    initial begin
        coal_seen   = 0;
        bursts_seen = 0;
        prev_load   = 1'b0;
        modelReset();
        doReset();

        $display("[TB] basic request, boundary, strobe and ack");
        idleCycles("t1_idle", 9);
        applyStimulus("t1_trig", 1'b1, 1'b1, 1'b0);
        idleCycles("t1_wait", 9);
        applyStimulus("t1_fb", 1'b1, 1'b0, 1'b1);
        idleCycles("t1_load", 8);
        checkBit("t1_toggle_final", bus.done_toggle, 1'b1);
        checkBit("t1_busy_final", bus.update_busy, 1'b0);

        $display("[TB] triggers merged while pending");
        coal_seen   = 0;
        bursts_seen = 0;
        applyStimulus("t2_trig", 1'b1, 1'b1, 1'b0);
        idleCycles("t2_wait", 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t2_merge", 1'b1, 1'b1, 1'b0);
            idleCycles("t2_gap", 1);
        end
        applyStimulus("t2_fb", 1'b1, 1'b0, 1'b1);
        idleCycles("t2_load", 8);
        checkInt("t2_coalesced_count", coal_seen, 3);
        checkInt("t2_burst_count", bursts_seen, 1);
        checkBit("t2_toggle_final", bus.done_toggle, 1'b0);

        $display("[TB] trigger during load re-arms");
        bursts_seen = 0;
        applyStimulus("t3_trig", 1'b1, 1'b1, 1'b0);
        applyStimulus("t3_fb", 1'b1, 1'b0, 1'b1);
        applyStimulus("t3_rearm", 1'b1, 1'b1, 1'b0);
        idleCycles("t3_wait", 5);
        applyStimulus("t3_fb2", 1'b1, 1'b0, 1'b1);
        idleCycles("t3_load", 8);
        checkInt("t3_burst_count", bursts_seen, 2);
        checkBit("t3_toggle_final", bus.done_toggle, 1'b0);

        $display("[TB] enable gating and abort");
        applyStimulus("t4_drop", 1'b0, 1'b1, 1'b0);
        idleCycles("t4_idle", 3);
        applyStimulus("t4_trig", 1'b1, 1'b1, 1'b0);
        idleCycles("t4_wait", 2);
        applyStimulus("t4_abort", 1'b0, 1'b0, 1'b0);
        applyStimulus("t4_fb_idle", 1'b1, 1'b0, 1'b1);
        idleCycles("t4_after", 3);

        $display("[TB] trigger and boundary together from idle");
        applyStimulus("t5_both", 1'b1, 1'b1, 1'b1);
        idleCycles("t5_wait", 3);
        applyStimulus("t5_fb", 1'b1, 1'b0, 1'b1);
        idleCycles("t5_load", 8);

        $display("[TB] long wait without boundary");
        applyStimulus("t6_trig", 1'b1, 1'b1, 1'b0);
        idleCycles("t6_wait", 16);
        applyStimulus("t6_fb", 1'b1, 1'b0, 1'b1);
        idleCycles("t6_drain", 8);

        $display("[TB] reset in the middle of a load strobe");
        applyStimulus("t7_trig", 1'b1, 1'b1, 1'b0);
        applyStimulus("t7_fb", 1'b1, 1'b0, 1'b1);
        applyStimulus("t7_load", 1'b1, 1'b0, 1'b0);
        checkBit("t7_load_before", bus.update_load, 1'b1);
        doReset();
        idleCycles("t7_after", 4);

        $display("[TB] random run");
        for (int i = 0; i < 800; i++) begin
            applyStimulus("rand",
                          ($urandom % 10) != 0,
                          ($urandom % 6) == 0,
                          ($urandom % 12) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
